// File: rtl/fwd_prop_pkg.sv
// Shared definitions for the forward-propagation sequencer: datapath operation
// codes, sequencer state encoding and default layer sizes.
package fwd_prop_pkg;

  localparam int N_IN_DEF  = 9;
  localparam int N_HID_DEF = 5;
  localparam int SEL_W     = 4;
  localparam int CTRL_W    = 4;
  localparam int PCNT_W    = 16;

  localparam logic [CTRL_W-1:0] C_IDLE  = 4'd0;
  localparam logic [CTRL_W-1:0] C_CLR   = 4'd1;
  localparam logic [CTRL_W-1:0] C_MAC   = 4'd2;
  localparam logic [CTRL_W-1:0] C_BIAS  = 4'd3;
  localparam logic [CTRL_W-1:0] C_ACT   = 4'd4;
  localparam logic [CTRL_W-1:0] C_P2S   = 4'd5;
  localparam logic [CTRL_W-1:0] C_MAC3  = 4'd6;
  localparam logic [CTRL_W-1:0] C_BIAS3 = 4'd7;
  localparam logic [CTRL_W-1:0] C_ACT3  = 4'd8;
  localparam logic [CTRL_W-1:0] C_UPD   = 4'd9;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_L2_MAC,
    S_L2_BIAS,
    S_L2_ACT,
    S_P2S_LOAD,
    S_L3_MAC,
    S_L3_BIAS,
    S_L3_ACT,
    S_FDONE,
    S_UPD,
    S_UDONE
  } state_t;

endpackage

// File: rtl/fwd_prop_seq_idx_cnt.sv
// Loadable sweep index counter; tc flags that the current index equals the
// sweep's last value so the sequencer can leave the sweep on that cycle.
module seq_idx_cnt
  import fwd_prop_pkg::*;
#(
  parameter int W = SEL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;
  assign tc  = (cnt_reg == last);

endmodule

// File: rtl/fwd_prop_seq.sv
// Forward-pass / update sequencer: sole driver of the 9-5-4 datapath ctrl/sel
// buses, stepping through MAC, bias, activation and serialisation phases.
module fwd_prop_seq
  import fwd_prop_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_HID = N_HID_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              upd_start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CTRL_W-1:0] ctrl,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              done,
  output logic              upd_done,
  output logic [PCNT_W-1:0] pass_cnt
);

  localparam logic [SEL_W-1:0] IN_LAST  = SEL_W'(N_IN - 1);
  localparam logic [SEL_W-1:0] HID_LAST = SEL_W'(N_HID - 1);

  state_t              state_reg, state_next;
  logic                busy_reg, done_reg, upd_done_reg;
  logic [PCNT_W-1:0]   pass_cnt_reg;
  logic                cnt_load, cnt_en, idx_tc;
  logic [SEL_W-1:0]    cnt_last, idx;

  assign cnt_last = (state_reg == S_L3_MAC) ? HID_LAST : IN_LAST;

  seq_idx_cnt #(.W(SEL_W)) u_idx (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val ('0),
    .en       (cnt_en),
    .last     (cnt_last),
    .cnt      (idx),
    .tc       (idx_tc)
  );

  // Outside a sweep the index is held at zero so sel reads 0 in every
  // single-cycle phase and each sweep starts from index 0.
  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b1;
    cnt_en     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start)          state_next = S_CLR;
        else if (upd_start) state_next = S_UPD;
      end
      S_CLR:      state_next = S_L2_MAC;
      S_L2_MAC: begin
        cnt_load = 1'b0;
        if (in_valid) begin
          if (idx_tc) begin
            state_next = S_L2_BIAS;
            cnt_load   = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      S_L2_BIAS:  state_next = S_L2_ACT;
      S_L2_ACT:   state_next = S_P2S_LOAD;
      S_P2S_LOAD: state_next = S_L3_MAC;
      S_L3_MAC: begin
        if (idx_tc) begin
          state_next = S_L3_BIAS;
        end else begin
          cnt_load = 1'b0;
          cnt_en   = 1'b1;
        end
      end
      S_L3_BIAS:  state_next = S_L3_ACT;
      S_L3_ACT:   state_next = S_FDONE;
      S_FDONE:    state_next = S_IDLE;
      S_UPD: begin
        if (idx_tc) begin
          state_next = S_UDONE;
        end else begin
          cnt_load = 1'b0;
          cnt_en   = 1'b1;
        end
      end
      S_UDONE:    state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
    if (abort && (state_reg != S_IDLE)) begin
      state_next = S_IDLE;
      cnt_load   = 1'b1;
      cnt_en     = 1'b0;
    end
  end

  always_comb begin
    ctrl = C_IDLE;
    case (state_reg)
      S_CLR:      ctrl = C_CLR;
      S_L2_MAC:   ctrl = in_valid ? C_MAC : C_IDLE;
      S_L2_BIAS:  ctrl = C_BIAS;
      S_L2_ACT:   ctrl = C_ACT;
      S_P2S_LOAD: ctrl = C_P2S;
      S_L3_MAC:   ctrl = C_MAC3;
      S_L3_BIAS:  ctrl = C_BIAS3;
      S_L3_ACT:   ctrl = C_ACT3;
      S_UPD:      ctrl = C_UPD;
      default:    ctrl = C_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      upd_done_reg <= 1'b0;
      pass_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      busy_reg     <= (state_next != S_IDLE);
      done_reg     <= (state_next == S_FDONE);
      upd_done_reg <= (state_next == S_UDONE);
      if ((state_reg == S_FDONE) && !abort) begin
        pass_cnt_reg <= pass_cnt_reg + 1'b1;
      end
    end
  end

  assign in_ready = (state_reg == S_L2_MAC);
  assign sel      = idx;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign upd_done = upd_done_reg;
  assign pass_cnt = pass_cnt_reg;

endmodule
